// File: rtl/img_byte_fetcher.sv
// Byte-wide image reader for the segment-mask renderer. It serves reads from
// two 8-byte line buffers filled from 64-bit DDR words, with optional next-line prefetch.
module img_byte_fetcher #(
  parameter logic [27:0] IMG_BASE = 28'h0200000,
  parameter bit          PREFETCH = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        inval,
  input  logic [24:0] img_addr,
  input  logic        img_read,
  output logic        img_data_ready,
  output logic [7:0]  img_data,
  output logic [27:0] ddr_addr,
  output logic        ddr_req,
  input  logic        ddr_ack,
  input  logic [63:0] ddr_dout
);
  // Handshakes: img_read is accepted only at an IDLE edge and ready then drops.
  // ddr_req is held until a ddr_ack pulse, and that pulse carries ddr_dout.
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, PF_REQ, RESPOND} state_t;

  state_t      state, state_nxt;
  logic [24:0] addr_q;
  logic [21:0] tag_q [2];
  logic [63:0] line_q [2];
  logic [1:0]  vld;
  logic        mru;
  logic        pf_pend;
  logic [21:0] pf_tag;
  logic        discard;
  logic [21:0] last_tag;
  logic        last_vld;

  logic        accept, pf_issue, pf_drop;
  logic        hit0, hit1, hit, hit_way, pf_resident, victim, fill_ok, acked;
  logic [21:0] req_tag;

  function automatic logic [7:0] pick(input logic [63:0] w, input logic [2:0] b);
    return w[{b, 3'b000} +: 8];
  endfunction

  assign req_tag     = addr_q[24:3];
  assign hit0        = vld[0] && (tag_q[0] == req_tag);
  assign hit1        = vld[1] && (tag_q[1] == req_tag);
  assign hit         = hit0 || hit1;
  assign hit_way     = hit1;
  assign pf_resident = (vld[0] && (tag_q[0] == pf_tag)) || (vld[1] && (tag_q[1] == pf_tag));
  // The most recently used line always holds the last accepted address, so
  // evicting the other line protects it from prefetch fills.
  assign victim      = ~mru;
  assign fill_ok     = !discard && !inval;
  assign acked       = ddr_ack && ((state == MISS_REQ) || (state == PF_REQ));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pf_issue  = 1'b0;
    pf_drop   = 1'b0;
    case (state)
      IDLE: begin
        if (img_read) begin
          accept    = 1'b1;
          state_nxt = LOOKUP;
        end else if (PREFETCH && pf_pend) begin
          if (pf_resident) begin
            pf_drop = 1'b1;
          end else begin
            pf_issue  = 1'b1;
            state_nxt = PF_REQ;
          end
        end
      end
      LOOKUP:   state_nxt = hit ? RESPOND : MISS_REQ;
      MISS_REQ: if (ddr_ack) state_nxt = RESPOND;
      PF_REQ:   if (ddr_ack) state_nxt = IDLE;
      RESPOND:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      img_data_ready <= 1'b1;
      img_data       <= 8'h00;
      ddr_addr       <= 28'h0;
      ddr_req        <= 1'b0;
      addr_q         <= 25'h0;
      tag_q[0]       <= 22'h0;
      tag_q[1]       <= 22'h0;
      line_q[0]      <= 64'h0;
      line_q[1]      <= 64'h0;
      vld            <= 2'b00;
      mru            <= 1'b0;
      pf_pend        <= 1'b0;
      pf_tag         <= 22'h0;
      discard        <= 1'b0;
      last_tag       <= 22'h0;
      last_vld       <= 1'b0;
    end else begin
      if (accept) begin
        addr_q         <= img_addr;
        img_data_ready <= 1'b0;
      end
      if (state == RESPOND) img_data_ready <= 1'b1;

      if (state == LOOKUP) begin
        // Entering a new line arms a prefetch of the one after it.
        if (!last_vld || (req_tag != last_tag)) begin
          pf_pend <= 1'b1;
          pf_tag  <= req_tag + 22'd1;
        end
        last_tag <= req_tag;
        last_vld <= 1'b1;
        if (hit) begin
          img_data <= pick(line_q[hit_way], addr_q[2:0]);
          mru      <= hit_way;
        end else begin
          ddr_addr <= IMG_BASE + {3'b000, req_tag, 3'b000};
          ddr_req  <= 1'b1;
          discard  <= 1'b0;
        end
      end

      if (pf_issue) begin
        ddr_addr <= IMG_BASE + {3'b000, pf_tag, 3'b000};
        ddr_req  <= 1'b1;
        pf_pend  <= 1'b0;
        discard  <= 1'b0;
      end
      if (pf_drop) pf_pend <= 1'b0;

      if (acked) begin
        ddr_req        <= 1'b0;
        line_q[victim] <= ddr_dout;
        tag_q[victim]  <= (state == MISS_REQ) ? req_tag : pf_tag;
        if (fill_ok) vld[victim] <= 1'b1;
        if (state == MISS_REQ) begin
          img_data <= pick(ddr_dout, addr_q[2:0]);
          mru      <= victim;
        end
      end

      // An in-flight request still completes, but its fill must not revive a line.
      if (inval) begin
        vld      <= 2'b00;
        pf_pend  <= 1'b0;
        last_vld <= 1'b0;
        if ((state == MISS_REQ) || (state == PF_REQ)) discard <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_img_byte_fetcher.sv
// Bench for img_byte_fetcher: a DDR responder backed by a synthetic image ROM,
// scenario tasks for the directed cases and a randomized read stream.
module tb_img_byte_fetcher;
  localparam logic [27:0] IMG_BASE = 28'h0200000;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        inval;
  logic [24:0] img_addr;
  logic        img_read;
  logic        img_data_ready;
  logic [7:0]  img_data;
  logic [27:0] ddr_addr;
  logic        ddr_req;
  logic        ddr_ack;
  logic [63:0] ddr_dout;

  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [63:0] resp_dout = 64'h0;
  int          ddr_lat = 1;
  logic [27:0] req_log[$];
  bit          ready_drop;

  int checks = 0;
  int failures = 0;

  assign ddr_ack  = resp_ack | stray_ack;
  assign ddr_dout = resp_dout;

  img_byte_fetcher #(.IMG_BASE(IMG_BASE), .PREFETCH(1'b1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .inval(inval),
    .img_addr(img_addr), .img_read(img_read),
    .img_data_ready(img_data_ready), .img_data(img_data),
    .ddr_addr(ddr_addr), .ddr_req(ddr_req), .ddr_ack(ddr_ack), .ddr_dout(ddr_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // Image ROM contents: byte i is a mix of its index bytes (equals i below 256).
  function automatic logic [7:0] img_byte(input logic [24:0] i);
    return i[7:0] ^ i[15:8] ^ i[23:16] ^ {7'd0, i[24]};
  endfunction

  function automatic logic [63:0] mem_word(input logic [27:0] a);
    logic [27:0] off;
    logic [24:0] idx;
    logic [63:0] w;
    off = a - IMG_BASE;
    idx = off[24:0];
    for (int b = 0; b < 8; b++) w[8*b +: 8] = img_byte(idx + 25'(b));
    return w;
  endfunction

  function automatic logic [27:0] line_addr(input logic [24:0] a);
    return IMG_BASE + {3'b000, a[24:3], 3'b000};
  endfunction

  // DDR responder: logs each request and acks after ddr_lat cycles unless reset intervenes.
  logic [27:0] rsp_a;
  bit          rsp_abort;
  always begin
    @(posedge clk_sys); #1;
    if (reset_n && ddr_req) begin
      rsp_a = ddr_addr;
      rsp_abort = 1'b0;
      req_log.push_back(rsp_a);
      for (int i = 1; i < ddr_lat; i++) begin
        @(posedge clk_sys); #1;
        if (!reset_n) begin
          rsp_abort = 1'b1;
          break;
        end
      end
      if (!rsp_abort && reset_n) begin
        resp_ack  = 1'b1;
        resp_dout = mem_word(rsp_a);
        @(posedge clk_sys); #1;
        resp_ack  = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk_sys); #1; end
  endtask

  task automatic pulse_inval();
    inval = 1'b1;
    @(posedge clk_sys); #1;
    inval = 1'b0;
  endtask

  // Issues one read and returns the stall (ready-low cycles), data and demand requests.
  task automatic do_read(input logic [24:0] a, output int stall, output logic [7:0] d,
                         output int nreq, output logic [27:0] raddr);
    int n0;
    int g;
    g = 0;
    img_addr = a;
    img_read = 1'b1;
    do begin @(posedge clk_sys); #1; g++; end while (img_data_ready && g < 200);
    img_read = 1'b0;
    n0 = req_log.size();
    stall = 0;
    while (!img_data_ready && g < 400) begin
      stall++;
      @(posedge clk_sys); #1;
      g++;
    end
    if (g >= 200) stall = -1;
    d = img_data;
    nreq = req_log.size() - n0;
    raddr = (nreq > 0) ? req_log[$] : 28'h0;
  endtask

  // Waits for a request to be logged and then retired; notes any ready drop meanwhile.
  task automatic wait_new_req(input int n0, output bit ok);
    int g;
    g = 0;
    ready_drop = 1'b0;
    while (req_log.size() == n0 && g < 40) begin @(posedge clk_sys); #1; g++; end
    while (ddr_req && g < 80) begin
      if (!img_data_ready) ready_drop = 1'b1;
      @(posedge clk_sys); #1;
      g++;
    end
    ok = (req_log.size() > n0) && !ddr_req;
  endtask

  task automatic test_reset();
    checks++; if (img_data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", img_data_ready); end
    checks++; if (img_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", img_data); end
    checks++; if (ddr_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", ddr_req); end
    checks++; if (ddr_addr !== 28'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", ddr_addr); end
  endtask

  task automatic test_cold_miss();
    int st, nr; logic [7:0] d; logic [27:0] ra;
    ddr_lat = 3;
    do_read(25'd0, st, d, nr, ra);
    checks++; if (nr !== 1 || ra !== IMG_BASE) begin failures++; $display("FAIL cold_req got n=%0d addr=%h exp n=1 addr=%h", nr, ra, IMG_BASE); end
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL cold_data got=%h exp=00", d); end
    checks++; if (st !== 5) begin failures++; $display("FAIL cold_stall got=%0d exp=5", st); end
  endtask

  task automatic test_hit();
    int st, nr; logic [7:0] d; logic [27:0] ra;
    do_read(25'd5, st, d, nr, ra);
    checks++; if (nr !== 0) begin failures++; $display("FAIL hit_noreq got=%0d exp=0", nr); end
    checks++; if (d !== 8'h05) begin failures++; $display("FAIL hit_data got=%h exp=05", d); end
    checks++; if (st !== 2) begin failures++; $display("FAIL hit_stall got=%0d exp=2", st); end
  endtask

  task automatic test_prefetch();
    int st, nr, n0; logic [7:0] d; logic [27:0] ra; bit ok;
    n0 = req_log.size();
    wait_new_req(n0, ok);
    checks++; if (!ok || req_log[$] !== IMG_BASE + 28'd8) begin failures++; $display("FAIL pf_addr got ok=%0d addr=%h exp=%h", ok, req_log[$], IMG_BASE + 28'd8); end
    checks++; if (ready_drop !== 1'b0) begin failures++; $display("FAIL pf_ready got drop=%0d exp=0", ready_drop); end
    do_read(25'd8, st, d, nr, ra);
    checks++; if (nr !== 0 || st !== 2 || d !== 8'h08) begin failures++; $display("FAIL pf_hit got n=%0d stall=%0d data=%h exp 0/2/08", nr, st, d); end
  endtask

  task automatic test_inval_prefetch();
    int st, nr, n0, g; logic [7:0] d; logic [27:0] ra; bit ok;
    ddr_lat = 6;
    n0 = req_log.size();
    g = 0;
    while (req_log.size() == n0 && g < 20) begin @(posedge clk_sys); #1; g++; end
    checks++; if (req_log.size() == n0 || ddr_addr !== IMG_BASE + 28'd16) begin failures++; $display("FAIL inv_pf_addr got=%h exp=%h", ddr_addr, IMG_BASE + 28'd16); end
    cycles(2);
    pulse_inval();
    wait_new_req(n0, ok);
    cycles(2);
    do_read(25'd8, st, d, nr, ra);
    checks++; if (nr !== 1 || ra !== IMG_BASE + 28'd8) begin failures++; $display("FAIL inv_miss8 got n=%0d addr=%h exp n=1 addr=%h", nr, ra, IMG_BASE + 28'd8); end
    checks++; if (d !== 8'h08 || st !== 8) begin failures++; $display("FAIL inv_data8 got data=%h stall=%0d exp 08/8", d, st); end
    do_read(25'd16, st, d, nr, ra);
    checks++; if (nr !== 1 || ra !== IMG_BASE + 28'd16 || d !== 8'h10) begin failures++; $display("FAIL inv_discard got n=%0d addr=%h data=%h exp 1/%h/10", nr, ra, d, IMG_BASE + 28'd16); end
  endtask

  task automatic test_back_to_back();
    int st, nr, n0; logic [7:0] d; logic [27:0] ra; bit ok;
    ddr_lat = 2;
    do_read(25'd17, st, d, nr, ra);
    checks++; if (nr !== 0 || st !== 2 || d !== 8'h11) begin failures++; $display("FAIL b2b_demand got n=%0d stall=%0d data=%h exp 0/2/11", nr, st, d); end
    n0 = req_log.size();
    wait_new_req(n0, ok);
    checks++; if (!ok || req_log[$] !== IMG_BASE + 28'd24) begin failures++; $display("FAIL b2b_deferred_pf got=%h exp=%h", req_log[$], IMG_BASE + 28'd24); end
  endtask

  task automatic test_tag_wrap();
    int st, nr, n0; logic [7:0] d; logic [27:0] ra; bit ok;
    logic [24:0] top;
    top = 25'h1FFFFF8;
    pulse_inval();
    do_read(top + 25'd6, st, d, nr, ra);
    checks++; if (nr !== 1 || ra !== IMG_BASE + 28'h1FFFFF8 || d !== img_byte(top + 25'd6)) begin failures++; $display("FAIL wrap_miss got n=%0d addr=%h data=%h exp 1/%h/%h", nr, ra, d, IMG_BASE + 28'h1FFFFF8, img_byte(top + 25'd6)); end
    n0 = req_log.size();
    wait_new_req(n0, ok);
    checks++; if (!ok || req_log[$] !== IMG_BASE) begin failures++; $display("FAIL wrap_pf got=%h exp=%h", req_log[$], IMG_BASE); end
    do_read(25'd3, st, d, nr, ra);
    checks++; if (nr !== 0 || st !== 2 || d !== 8'h03) begin failures++; $display("FAIL wrap_hit got n=%0d stall=%0d data=%h exp 0/2/03", nr, st, d); end
  endtask

  task automatic test_random();
    int st, nr; logic [7:0] d; logic [27:0] ra;
    logic [24:0] a, prev;
    bit prev_ok;
    int sel;
    prev = 25'd3;
    prev_ok = 1'b1;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      if (sel < 2)       a = {prev[24:3], 3'($urandom_range(0, 7))};
      else if (sel == 2) a = {prev[24:3] + 22'd1, 3'($urandom_range(0, 7))};
      else               a = 25'($urandom_range(0, 32'h1FFFFFF));
      ddr_lat = $urandom_range(1, 4);
      do_read(a, st, d, nr, ra);
      checks++; if (d !== img_byte(a)) begin failures++; $display("FAIL rnd_data addr=%h got=%h exp=%h", a, d, img_byte(a)); end
      if (nr == 0) begin
        checks++; if (st !== 2) begin failures++; $display("FAIL rnd_hit_stall addr=%h got=%0d exp=2", a, st); end
      end else begin
        checks++; if (ra !== line_addr(a) || st !== 2 + ddr_lat) begin failures++; $display("FAIL rnd_miss addr=%h got %h/%0d exp %h/%0d", a, ra, st, line_addr(a), 2 + ddr_lat); end
      end
      if (prev_ok && a[24:3] == prev[24:3]) begin
        checks++; if (nr !== 0) begin failures++; $display("FAIL rnd_same_line addr=%h got n=%0d exp=0", a, nr); end
      end
      prev = a;
      prev_ok = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        pulse_inval();
        prev_ok = 1'b0;
      end
      cycles($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    int st, nr, g; logic [7:0] d; logic [27:0] ra;
    bit stray_seen;
    pulse_inval();
    cycles(12);
    ddr_lat = 30;
    img_addr = 25'd40;
    img_read = 1'b1;
    g = 0;
    do begin @(posedge clk_sys); #1; g++; end while (img_data_ready && g < 100);
    img_read = 1'b0;
    while (!ddr_req && g < 120) begin @(posedge clk_sys); #1; g++; end
    checks++; if (ddr_req !== 1'b1 || ddr_addr !== IMG_BASE + 28'd40) begin failures++; $display("FAIL rst_pre_req got req=%b addr=%h exp 1/%h", ddr_req, ddr_addr, IMG_BASE + 28'd40); end
    cycles(2);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ddr_req !== 1'b0 || img_data_ready !== 1'b1) begin failures++; $display("FAIL rst_async got req=%b ready=%b exp 0/1", ddr_req, img_data_ready); end
    cycles(3);
    reset_n = 1'b1;
    cycles(1);
    stray_ack = 1'b1;
    cycles(1);
    stray_ack = 1'b0;
    stray_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ddr_req || !img_data_ready) stray_seen = 1'b1;
      cycles(1);
    end
    checks++; if (stray_seen !== 1'b0) begin failures++; $display("FAIL rst_stray_ack got disturbed=%0d exp=0", stray_seen); end
    ddr_lat = 2;
    do_read(25'd0, st, d, nr, ra);
    checks++; if (nr !== 1 || ra !== IMG_BASE || d !== 8'h00 || st !== 4) begin failures++; $display("FAIL rst_cold got n=%0d addr=%h data=%h stall=%0d exp 1/%h/00/4", nr, ra, d, st, IMG_BASE); end
  endtask

  initial begin
    reset_n  = 1'b0;
    inval    = 1'b0;
    img_read = 1'b0;
    img_addr = 25'd0;
    cycles(3);
    test_reset();
    reset_n = 1'b1;
    cycles(2);
    test_cold_miss();
    test_hit();
    test_prefetch();
    test_inval_prefetch();
    test_back_to_back();
    test_tag_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule

// File: doc/img_byte_fetcher.md
Name: img_byte_fetcher

Overview:
- Upstream neighbour of the segment-mask renderer.
- Serves its byte-wide image/mask reads (address, read strobe, data-ready, data byte) from 64-bit DDR words.
- Holds two 8-byte line buffers: the current line and a prefetched next line. Sequential rendering therefore almost never stalls on DDR.
- Sits between the renderer and the DDR read arbiter. The image ROM is preloaded at IMG_BASE.

Parameters:
- IMG_BASE, 28'h0200000: DDR byte address of image byte 0. Must be 8-byte aligned.
- PREFETCH, 1: 1 enables next-line prefetch; 0 fetches on miss only.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  reset
- inval  in  1  invalidate both lines (ROM reload); single-cycle pulse
- img_addr  in  25  byte address, sampled with img_read
- img_read  in  1  read request, level
- img_data_ready  out  1  1 = idle and img_data valid; 0 = busy
- img_data  out  8  byte at last accepted address
- ddr_addr  out  28  DDR byte address, [2:0] always 0
- ddr_req  out  1  read request, held until ddr_ack
- ddr_ack  in  1  one-cycle pulse, ddr_dout valid
- ddr_dout  in  64  little-endian word; byte n at [8n+7:8n]

Behaviour:
- Reset is asynchronous and active-low; there is one clock, clk_sys.
- Reset values:
  - img_data_ready=1, img_data=0
  - ddr_req=0, ddr_addr=0
  - both line valid bits=0
  - state=IDLE
- Lines: L0 and L1, each with a 22-bit tag (addr[24:3]), a valid bit and 64 bits of data. A hit is tag match with valid set.
- States: IDLE, LOOKUP, MISS_REQ, PF_REQ, RESPOND.
- IDLE:
  - img_data_ready=1.
  - If img_read=1, latch img_addr, drop ready next cycle, go to LOOKUP.
  - If img_read=0 and a prefetch is pending, go to PF_REQ.
- LOOKUP (one cycle):
  - On a hit, select the byte at addr[2:0] into img_data and go to RESPOND.
  - On a miss, set ddr_addr=IMG_BASE+{addr[24:3],3'b0}, ddr_req=1, go to MISS_REQ.
- MISS_REQ:
  - Hold ddr_req until ddr_ack.
  - On ack, write the line into the victim (the line not hit most recently), set tag and valid, load img_data from ddr_dout, and go to RESPOND.
  - Deassert ddr_req the cycle after ack.
- RESPOND: set img_data_ready=1 and return to IDLE.
- Latency from img_read accepted to ready high:
  - hit: 3 cycles (ready low for exactly 2 cycles)
  - miss: 3 cycles + DDR latency
- Prefetch (PREFETCH=1):
  - Trigger: the first access to a line.
  - The next line (tag+1) is marked pending unless already resident.
  - Prefetch is issued only from IDLE, and only when no img_read is present. img_read always has priority at IDLE.
  - Once PF_REQ has issued ddr_req, it completes and fills the victim. ready stays 1 during PF_REQ.
  - An img_read arriving during PF_REQ is not accepted. ready stays high, but acceptance waits until the fill completes and the FSM returns to IDLE.
  - A prefetch never evicts the line containing the last accepted address.
- Tag wrap: incrementing tag 22'h3FFFFF wraps to 0 and is prefetched normally.
- img_data holds its value until the next accepted read completes.
- inval:
  - Clears both valid bits and the pending prefetch next cycle.
  - If a DDR request is outstanding, the request completes but the fill is discarded for prefetches.
  - A demand miss still returns its byte but leaves the line invalid.
- img_read held high after RESPOND: a new request is accepted in the following IDLE cycle, and img_addr is re-sampled.
- Reset mid-transfer: ddr_req drops immediately. A late ddr_ack after reset is ignored (the FSM is in IDLE with no pending request).

Test Plan:
- Cold read, addr 0:
  - ddr_req with ddr_addr=IMG_BASE.
  - ack with ddr_dout=64'h0706050403020100 gives img_data=8'h00, ready low 2+latency cycles.
- Read addr 5 afterwards: hit, no ddr_req, img_data=8'h05, ready low exactly 2 cycles.
- Idle after addr 5 with PREFETCH=1:
  - ddr_req to IMG_BASE+8.
  - Then read addr 8: hit, 2-cycle stall.
- Read addr 16, then img_read asserted in the same cycle the prefetch could start: demand wins, prefetch is deferred, no ddr_req overlap.
- inval pulse during an outstanding prefetch ack, then read addr 8: miss, fresh ddr_req to IMG_BASE+8.
- reset_n low while ddr_req=1:
  - ddr_req=0 and ready=1 immediately.
  - A stray ddr_ack is ignored, and the next read addr 0 misses.
